uart_rx: RTL and testbench

Receive half of the board UART link: deserialises an 8N1 asynchronous serial stream from the host into bytes for the lab datapath. It is the companion to the transmit block and uses the same CLKS_PER_BIT timing convention. Each byte is validated by checking its start and stop bits. A good byte produces a one-cycle strobe; a bad stop bit produces a framing-error strobe. The block runs on the single system clock with no external baud tick.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Receive half of the board UART link. Deserialises an 8N1 asynchronous serial
// stream into bytes. The block oversamples with the system clock: it finds the
// middle of the start bit, then samples each following bit one bit period
// later. A good stop bit yields a one-cycle data-valid strobe, and a low stop
// bit yields a one-cycle framing-error strobe.
//
// Parameters
//   CLKS_PER_BIT    system clocks per serial bit (legal 4..255)
// Ports
//   i_Clock         system clock, rising edge
//   i_Reset         synchronous active-high reset
//   i_Rx_Serial     asynchronous serial input, idles high
//   o_Rx_DV         one-cycle strobe: o_Rx_Byte holds a new good byte
//   o_Rx_Byte       last good byte, updated only with o_Rx_DV
//   o_Rx_Frame_Err  one-cycle strobe: stop bit sampled low, byte discarded
//   o_Rx_Active     high from start-bit detection until back in IDLE
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  // Half a bit period, rounded down: the start bit is re-checked here so every
  // later sample lands near the middle of its bit.
  localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t     state;
  logic       sync1;
  logic       sync2;
  logic       r_rx;
  logic [7:0] clk_count;
  logic [2:0] bit_index;
  logic [7:0] shadow;

  // Two-flop synchroniser. Both flops reset to the idle level so a reset never
  // looks like a falling start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, exactly as the hardware does.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_Rx_Serial;
      sync2 <= sync1;
    end
  end

  assign r_rx = sync2;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      // NOTE: the shadow byte is an ordinary 8-bit register, not a memory, so
      // it is reset along with the rest of the datapath.
      state          <= IDLE;
      clk_count      <= 8'd0;
      bit_index      <= 3'd0;
      shadow         <= 8'h00;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_count      <= 8'd0;
          bit_index      <= 3'd0;
          o_Rx_DV        <= 1'b0;
          o_Rx_Frame_Err <= 1'b0;
          if (!r_rx) begin
            state       <= START;
            o_Rx_Active <= 1'b1;
          end
        end

        START: begin
          if (clk_count < HALF_CNT) begin
            clk_count <= clk_count + 8'd1;
          end else if (!r_rx) begin
            clk_count <= 8'd0;
            state     <= DATA;
          end else begin
            // Line went high again before mid start bit: a glitch, not a frame.
            state       <= IDLE;
            o_Rx_Active <= 1'b0;
          end
        end

        DATA: begin
          if (clk_count < LAST_CNT) begin
            clk_count <= clk_count + 8'd1;
          end else begin
            clk_count         <= 8'd0;
            shadow[bit_index] <= r_rx;  // LSB arrives first
            if (bit_index == 3'd7) begin
              bit_index <= 3'd0;
              state     <= STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end
        end

        STOP: begin
          if (clk_count < LAST_CNT) begin
            clk_count <= clk_count + 8'd1;
          end else begin
            clk_count <= 8'd0;
            if (r_rx) begin
              o_Rx_Byte <= shadow;
              o_Rx_DV   <= 1'b1;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
            end
            state <= CLEANUP;
          end
        end

        CLEANUP: begin
          // Leaves one cycle after a good stop (mid stop bit), so a start edge
          // arriving right after the stop bit is still caught. After a break
          // the line stays low and the block waits here.
          o_Rx_DV        <= 1'b0;
          o_Rx_Frame_Err <= 1'b0;
          if (r_rx) begin
            state       <= IDLE;
            o_Rx_Active <= 1'b0;
          end
        end

        default: begin
          state          <= IDLE;
          o_Rx_DV        <= 1'b0;
          o_Rx_Frame_Err <= 1'b0;
          o_Rx_Active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Bench for uart_rx with CLKS_PER_BIT = 8. The stimulus process drives an
// ideal serial line and, for every frame that should produce a strobe, pushes
// the expected strobe kind, byte and cycle into a queue. A separate monitor
// pops and compares whenever the DUT raises o_Rx_DV or o_Rx_Frame_Err.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 8;
  // From the line going low at a falling edge, the next rising edge is e0 and
  // the strobe is visible after e78 = e2 + (H+1) + 9*CPB with H = 3.
  localparam int STROBE_LAT = 79;

  typedef struct {
    logic        fe;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       clk;
  logic       i_Reset;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;

  int unsigned cyc;
  int          checks;
  int          errors;
  exp_t        exp_q[$];
  logic [7:0]  last_good;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Reset        (i_Reset),
    .i_Rx_Serial    (i_Rx_Serial),
    .o_Rx_DV        (o_Rx_DV),
    .o_Rx_Byte      (o_Rx_Byte),
    .o_Rx_Frame_Err (o_Rx_Frame_Err),
    .o_Rx_Active    (o_Rx_Active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: compares every strobe against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (o_Rx_DV || o_Rx_Frame_Err) begin
      check("dv_fe_exclusive", 32'(o_Rx_DV & o_Rx_Frame_Err), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got dv=%0b fe=%0b byte=%0h at cycle %0d, expected no strobe",
                 o_Rx_DV, o_Rx_Frame_Err, o_Rx_Byte, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_is_frame_err", 32'(o_Rx_Frame_Err), 32'(e.fe));
        check("strobe_byte", 32'(o_Rx_Byte), 32'(e.data));
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  // Drives one 10-bit frame starting at the current falling edge and returns
  // at the falling edge 80 cycles later, with the stop level still on the line.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    exp_t e;
    i_Rx_Serial = 1'b0;
    e.fe   = !stop_bit;
    e.data = stop_bit ? data : last_good;
    e.cyc  = cyc + STROBE_LAT;
    exp_q.push_back(e);
    if (stop_bit) last_good = data;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) check("active_mid_frame", 32'(o_Rx_Active), 32'd1);
      i_Rx_Serial = data[i];
      repeat (CPB) @(negedge clk);
    end
    i_Rx_Serial = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_Rx_Serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] aborted;
    checks      = 0;
    errors      = 0;
    last_good   = 8'h00;
    i_Reset     = 1'b1;
    i_Rx_Serial = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_dv", 32'(o_Rx_DV), 32'd0);
    check("reset_byte", 32'(o_Rx_Byte), 32'h00);
    check("reset_fe", 32'(o_Rx_Frame_Err), 32'd0);
    check("reset_active", 32'(o_Rx_Active), 32'd0);
    i_Reset = 1'b0;
    idle(4);

    // Single byte; active must already be low one cycle after the DV cycle
    send_frame(8'h37, 1'b1);
    check("single_active_after_dv", 32'(o_Rx_Active), 32'd0);
    check("single_dv_one_cycle", 32'(o_Rx_DV), 32'd0);
    idle(16);

    // Back-to-back frames, no idle gap: strobes land 80 cycles apart
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle(16);

    // Glitch: two cycles low is shorter than H+1, so no frame is accepted
    i_Rx_Serial = 1'b0;
    repeat (2) @(negedge clk);
    i_Rx_Serial = 1'b1;
    @(negedge clk);
    check("glitch_active_seen", 32'(o_Rx_Active), 32'd1);
    repeat (5) @(negedge clk);
    check("glitch_active_dropped", 32'(o_Rx_Active), 32'd0);
    idle(16);

    // Framing error followed by a break; byte output keeps 0xA5
    send_frame(8'h5A, 1'b0);
    repeat (40) @(negedge clk);
    check("break_holds_active", 32'(o_Rx_Active), 32'd1);
    check("break_keeps_byte", 32'(o_Rx_Byte), 32'hA5);
    i_Rx_Serial = 1'b1;
    repeat (4) @(negedge clk);
    check("break_release_idle", 32'(o_Rx_Active), 32'd0);
    idle(8);
    send_frame(8'h81, 1'b1);
    idle(16);

    // Reset during data bit 4 of 0xC3: no strobe, all outputs cleared
    aborted     = 8'hC3;
    i_Rx_Serial = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      i_Rx_Serial = aborted[i];
      repeat (CPB) @(negedge clk);
    end
    i_Rx_Serial = aborted[4];
    repeat (4) @(negedge clk);
    i_Reset     = 1'b1;
    i_Rx_Serial = 1'b1;
    @(negedge clk);
    check("midreset_dv", 32'(o_Rx_DV), 32'd0);
    check("midreset_byte", 32'(o_Rx_Byte), 32'h00);
    check("midreset_fe", 32'(o_Rx_Frame_Err), 32'd0);
    check("midreset_active", 32'(o_Rx_Active), 32'd0);
    i_Reset   = 1'b0;
    last_good = 8'h00;
    idle(24);
    send_frame(8'h3C, 1'b1);
    idle(16);

    check("all_strobes_seen", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
